// File: rtl/pano_phy_reset_ctrl.sv
// rtl/pano_phy_reset_ctrl.sv - Pano button debounce and Marvell PHY reset sequencer
// Toggles a PHY-on request per debounced press and publishes clk_stable around clock-mux switches.
module pano_phy_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int RST_MIN_CYCLES    = 250000,
  parameter int SETTLE_CYCLES     = 125000,
  parameter int LONG_PRESS_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_n,
  output logic gmii_rst_n,
  output logic clk_stable,
  output logic btn_pressed,
  output logic press_pulse,
  output logic long_pulse,
  output logic phy_on
);

  localparam int FSM_MAX = (RST_MIN_CYCLES > SETTLE_CYCLES) ? RST_MIN_CYCLES : SETTLE_CYCLES;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int FSM_W   = $clog2(FSM_MAX) + 1;
  localparam int HOLD_W  = $clog2(LONG_PRESS_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FSM_W-1:0]  RST_LAST    = FSM_W'(RST_MIN_CYCLES - 1);
  localparam logic [FSM_W-1:0]  SETTLE_LAST = FSM_W'(SETTLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_FULL   = HOLD_W'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {HOLD, OFF, UP, RUN} state_t;

  state_t            state_q, state_d;
  logic [FSM_W-1:0]  cnt_q, cnt_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              btn_q, btn_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic              phy_req_q, phy_req_d;
  logic              gmii_q, gmii_d;
  logic              stable_q, stable_d;
  logic              phy_on_q, phy_on_d;
  logic              s;

  always_comb begin
    // Sync flops carry the raw pin, so their idle value 1 means released.
    sync1_d = button_n;
    sync2_d = sync1_q;
    s       = ~sync2_q;

    btn_d     = btn_q;
    db_cnt_d  = '0;
    press_d   = 1'b0;
    phy_req_d = phy_req_q;
    if (s != btn_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_d   = s;
        press_d = s;
        if (s) phy_req_d = ~phy_req_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    hold_cnt_d = '0;
    long_d     = 1'b0;
    if (btn_q) begin
      hold_cnt_d = hold_cnt_q;
      if (hold_cnt_q != LONG_FULL) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      long_d = (hold_cnt_q == LONG_LAST);
    end

    state_d = state_q;
    cnt_d   = cnt_q + FSM_W'(1);
    case (state_q)
      HOLD: if (cnt_q == RST_LAST) state_d = OFF;
      OFF: begin
        cnt_d = '0;
        if (phy_req_q) state_d = UP;
      end
      // A request dropped mid-settle is only honoured once the clock has settled.
      UP:   if (cnt_q == SETTLE_LAST) state_d = phy_req_q ? RUN : HOLD;
      RUN: begin
        cnt_d = '0;
        if (!phy_req_q) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
    if (state_d != state_q) cnt_d = '0;

    gmii_d   = (state_d == UP) || (state_d == RUN);
    stable_d = (state_d == OFF) || (state_d == RUN);
    phy_on_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      btn_q      <= 1'b0;
      press_q    <= 1'b0;
      long_q     <= 1'b0;
      phy_req_q  <= 1'b0;
      gmii_q     <= 1'b0;
      stable_q   <= 1'b0;
      phy_on_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_q      <= btn_d;
      press_q    <= press_d;
      long_q     <= long_d;
      phy_req_q  <= phy_req_d;
      gmii_q     <= gmii_d;
      stable_q   <= stable_d;
      phy_on_q   <= phy_on_d;
    end
  end

  assign gmii_rst_n  = gmii_q;
  assign clk_stable  = stable_q;
  assign btn_pressed = btn_q;
  assign press_pulse = press_q;
  assign long_pulse  = long_q;
  assign phy_on      = phy_on_q;

endmodule
